// File: rtl/rsa_pkg.sv
// rsa_pkg: shared FSM state encoding, default lane width and a small helper
// used by the skew feeder.
package rsa_pkg;

    localparam int RSA_DW_DEFAULT = 32;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2,
        S_DONE   = 2'd3
    } feeder_state_e;

    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// skew_delay_line: DEPTH-stage register chain of width W; DEPTH=0 is a
// plain wire so lane 0 needs no special casing in the parent.
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    if (DEPTH == 0) begin : gWire
        logic unusedClockReset;
        assign unusedClockReset = clk ^ rst;
        assign q_o = d_i;
    end else begin : gChain
        logic [W-1:0] stage_q [DEPTH];

        // Shift the value one stage further down the chain every cycle.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
            end else begin
                stage_q[0] <= d_i;
                for (int k = 1; k < DEPTH; k++) stage_q[k] <= stage_q[k-1];
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/rsa_skew_feeder.sv
// rsa_skew_feeder: accepts up to L beats per job (A column + B row) and
// drives them onto the array edges with a skew equal to the lane index,
// then drains the skew pipeline and pulses done.
// Build macro RSA_FEEDER_ZERO_FILL_EN: lane data is forced to zero in every
// slot without a beat; when undefined, lanes hold their last beat value.
module rsa_skew_feeder
    import rsa_pkg::*;
#(
    parameter int X      = 4,
    parameter int Y      = 4,
    parameter int L      = 4,
    parameter int RSA_DW = RSA_DW_DEFAULT
) (
    input  logic                  clk,
    input  logic                  sys_rst,
    input  logic                  start,
    input  logic [$clog2(L):0]    k_len,
    output logic                  busy,
    output logic                  done,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [X*RSA_DW-1:0]   a_col,
    input  logic [Y*RSA_DW-1:0]   b_row,
    output logic [X*RSA_DW-1:0]   A_data,
    output logic [Y*RSA_DW-1:0]   B_data,
    output logic [Y-1:0]          new_cal_en,
    output logic [Y-1:0]          new_cal_done
);

    localparam int KW        = $clog2(L) + 1;
    localparam int DRAIN_LEN = maxInt(X, Y);
    localparam int CW        = $clog2(DRAIN_LEN) + 1;

    feeder_state_e state_q, state_d;
    logic [KW-1:0] len_q, len_d;
    logic [KW-1:0] beat_q, beat_d;
    logic [CW-1:0] drain_q, drain_d;
    logic          xferStrobe;
    logic          lastStrobe;

    logic [X*RSA_DW-1:0] aEntry_q, aIdle;
    logic [Y*RSA_DW-1:0] bEntry_q, bIdle;
    logic                enEntry_q;
    logic                lastEntry_q;

    // Job sequencing: next state, beat/drain counters and handshake outputs.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        beat_d     = beat_q;
        drain_d    = drain_q;
        busy       = 1'b0;
        done       = 1'b0;
        in_ready   = 1'b0;
        xferStrobe = 1'b0;
        lastStrobe = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d  = (k_len > KW'(L)) ? KW'(L) : k_len;
                    beat_d = '0;
                    state_d = (k_len == '0) ? S_DONE : S_STREAM;
                end
            end
            S_STREAM: begin
                busy       = 1'b1;
                in_ready   = (beat_q < len_q);
                xferStrobe = in_valid && in_ready;
                lastStrobe = xferStrobe && (beat_q == len_q - KW'(1));
                if (lastStrobe) begin
                    beat_d  = '0;
                    drain_d = '0;
                    state_d = S_DRAIN;
                end else if (xferStrobe) begin
                    beat_d = beat_q + KW'(1);
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (drain_q == CW'(DRAIN_LEN - 1)) begin
                    drain_d = '0;
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + CW'(1);
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state and counter registers.
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            beat_q  <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            drain_q <= drain_d;
        end
    end

`ifdef RSA_FEEDER_ZERO_FILL_EN
    assign aIdle = '0;
    assign bIdle = '0;
`else
    assign aIdle = aEntry_q;
    assign bIdle = bEntry_q;
`endif

    // Entry stage common to all lanes; the per-lane chains add the skew.
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            aEntry_q    <= '0;
            bEntry_q    <= '0;
            enEntry_q   <= 1'b0;
            lastEntry_q <= 1'b0;
        end else begin
            aEntry_q    <= xferStrobe ? a_col : aIdle;
            bEntry_q    <= xferStrobe ? b_row : bIdle;
            enEntry_q   <= xferStrobe;
            lastEntry_q <= lastStrobe;
        end
    end

    for (genvar i = 0; i < X; i++) begin : gALane
        skew_delay_line #(.DEPTH(i), .W(RSA_DW)) uADelay (
            .clk (clk),
            .rst (sys_rst),
            .d_i (aEntry_q[i*RSA_DW +: RSA_DW]),
            .q_o (A_data[i*RSA_DW +: RSA_DW])
        );
    end

    for (genvar j = 0; j < Y; j++) begin : gBLane
        skew_delay_line #(.DEPTH(j), .W(RSA_DW)) uBDelay (
            .clk (clk),
            .rst (sys_rst),
            .d_i (bEntry_q[j*RSA_DW +: RSA_DW]),
            .q_o (B_data[j*RSA_DW +: RSA_DW])
        );
        skew_delay_line #(.DEPTH(j), .W(2)) uStrobeDelay (
            .clk (clk),
            .rst (sys_rst),
            .d_i ({lastEntry_q, enEntry_q}),
            .q_o ({new_cal_done[j], new_cal_en[j]})
        );
    end

endmodule

// File: tb/tb_rsa_skew_feeder.sv
// tb_rsa_skew_feeder: randomized job stimulus with a scoreboard of expected
// lane beats (cycle, A value, B value, last flag) per column.
module tb_rsa_skew_feeder;

   localparam int X     = 4;
   localparam int Y     = 4;
   localparam int L     = 4;
   localparam int DW    = 32;
   localparam int KW    = $clog2(L) + 1;
   localparam int DRAIN = 4;
   localparam longint NEVER = 64'h3FFF_FFFF_FFFF_FFFF;

   logic            clk = 1'b0;
   logic            sys_rst, start, in_valid;
   logic [KW-1:0]   k_len;
   logic            busy, done, in_ready;
   logic [X*DW-1:0] a_col, A_data;
   logic [Y*DW-1:0] b_row, B_data;
   logic [Y-1:0]    new_cal_en, new_cal_done;

   int     tests = 0;
   int     fails = 0;
   longint cyc   = 0;

   typedef struct {
      longint          when;
      logic [DW-1:0]   aVal;
      logic [DW-1:0]   bVal;
      bit              last;
   } beat_t;

   beat_t         laneQ [Y][$];
   beat_t         popped;
   logic [DW-1:0] lastA [Y];
   logic [DW-1:0] lastB [Y];
   bit            jobOn    = 1'b0;
   int            acc      = 0;
   int            len      = 0;
   longint        lastDone = -1;

   rsa_skew_feeder #(.X(X), .Y(Y), .L(L), .RSA_DW(DW)) dut (
      .clk          (clk),
      .sys_rst      (sys_rst),
      .start        (start),
      .k_len        (k_len),
      .busy         (busy),
      .done         (done),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .a_col        (a_col),
      .b_row        (b_row),
      .A_data       (A_data),
      .B_data       (B_data),
      .new_cal_en   (new_cal_en),
      .new_cal_done (new_cal_done)
   );

   // Free-running clock and cycle counter used to timestamp expectations.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cyc);
      end
   endtask

   // Scoreboard monitor: checks what the DUT shows now, then records what
   // the coming edge will do according to the job rules.
   always @(negedge clk) begin
      if (sys_rst) begin
         checkOutput("resetOutputs",
                     {busy, done, in_ready, new_cal_en, new_cal_done, |A_data, |B_data}, '0);
         for (int j = 0; j < Y; j++) begin
            laneQ[j].delete();
            lastA[j] = '0;
            lastB[j] = '0;
         end
         jobOn    = 1'b0;
         acc      = 0;
         len      = 0;
         lastDone = -1;
      end else begin
         if (jobOn && cyc == lastDone) jobOn = 1'b0;
         checkOutput("busy", busy, jobOn);
         checkOutput("done", done, cyc == lastDone);
         checkOutput("inReady", in_ready, jobOn && acc < len);
         for (int j = 0; j < Y; j++) begin
            while (laneQ[j].size() > 0 && laneQ[j][0].when < cyc) begin
               checkOutput($sformatf("lane%0dMissedBeat", j), cyc, laneQ[j][0].when);
               void'(laneQ[j].pop_front());
            end
            if (new_cal_en[j]) begin
               if (laneQ[j].size() == 0) begin
                  checkOutput($sformatf("lane%0dSpuriousCalEn", j), new_cal_en[j], 1'b0);
               end else begin
                  popped = laneQ[j].pop_front();
                  checkOutput($sformatf("lane%0dBeatCycle", j), cyc, popped.when);
                  checkOutput($sformatf("laneA%0d", j), A_data[j*DW +: DW], popped.aVal);
                  checkOutput($sformatf("laneB%0d", j), B_data[j*DW +: DW], popped.bVal);
                  checkOutput($sformatf("calDone%0d", j), new_cal_done[j], popped.last);
                  lastA[j] = popped.aVal;
                  lastB[j] = popped.bVal;
               end
            end else begin
               checkOutput($sformatf("calDoneIdle%0d", j), new_cal_done[j], 1'b0);
`ifdef RSA_FEEDER_ZERO_FILL_EN
               checkOutput($sformatf("idleA%0d", j), A_data[j*DW +: DW], '0);
               checkOutput($sformatf("idleB%0d", j), B_data[j*DW +: DW], '0);
`else
               checkOutput($sformatf("holdA%0d", j), A_data[j*DW +: DW], lastA[j]);
               checkOutput($sformatf("holdB%0d", j), B_data[j*DW +: DW], lastB[j]);
`endif
            end
         end
         if (!jobOn && cyc > lastDone && start) begin
            len = (int'(k_len) > L) ? L : int'(k_len);
            acc = 0;
            if (len == 0) lastDone = cyc + 1;
            else begin
               jobOn    = 1'b1;
               lastDone = NEVER;
            end
         end else if (jobOn && acc < len && in_valid) begin
            for (int j = 0; j < Y; j++)
               laneQ[j].push_back('{cyc + 1 + j, a_col[j*DW +: DW], b_row[j*DW +: DW], acc == len - 1});
            acc++;
            if (acc == len) lastDone = cyc + 1 + DRAIN;
         end
      end
   end

   task automatic driveBeat(input int beat, input bit rnd);
      for (int i = 0; i < X; i++) a_col[i*DW +: DW] = rnd ? DW'($urandom) : DW'(10 * beat + i);
      for (int j = 0; j < Y; j++) b_row[j*DW +: DW] = rnd ? DW'($urandom) : DW'(100 * beat + j);
   endtask

   // One job: start pulse, beats with optional bubbles, an ignored start
   // while streaming, optional reset after some beats, extra valid slots.
   task automatic applyStimulus(input int kLen, input logic [15:0] bubbleMask, input bit useRandom,
                                input int resetAfter, input int extraValid);
      int effLen = (kLen > L) ? L : kLen;
      int beat   = 0;
      int slot   = 0;
      bit xferNow;
      bit aborted = 1'b0;
      @(posedge clk); #1;
      start = 1'b1; k_len = KW'(kLen); in_valid = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      while (beat < effLen && slot < 40 && !aborted) begin
         if (beat == resetAfter) begin
            sys_rst = 1'b1; in_valid = 1'b0;
            @(posedge clk); #1;
            sys_rst = 1'b0;
            aborted = 1'b1;
         end else begin
            in_valid = !(slot < 16 && bubbleMask[slot]);
            driveBeat(beat, useRandom || !in_valid);
            if (slot == 1) begin
               start = 1'b1; k_len = KW'(1);
            end
            @(negedge clk);
            xferNow = in_valid && in_ready;
            @(posedge clk); #1;
            start = 1'b0;
            if (xferNow) beat++;
            slot++;
         end
      end
      if (!aborted && beat < effLen) checkOutput("beatTimeout", beat, effLen);
      repeat (extraValid) begin
         in_valid = 1'b1;
         driveBeat(99, 1'b1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1;
   endtask

   initial begin
      sys_rst = 1'b1; start = 1'b0; in_valid = 1'b0; k_len = '0; a_col = '0; b_row = '0;
      repeat (3) @(posedge clk);
      #1 sys_rst = 1'b0;
      applyStimulus(4, 16'h0000, 1'b0, -1, 0);
      applyStimulus(3, 16'h0002, 1'b0, -1, 0);
      applyStimulus(0, 16'h0000, 1'b0, -1, 0);
      applyStimulus(7, 16'h0000, 1'b0, -1, 2);
      applyStimulus(4, 16'h0000, 1'b1, 2, 0);
      applyStimulus(4, 16'h0004, 1'b1, -1, 0);
      for (int r = 0; r < 16; r++)
         applyStimulus($urandom_range(0, 7), 16'($urandom) & 16'h0F0F, 1'b1, -1, $urandom_range(0, 2));
      for (int j = 0; j < Y; j++) checkOutput($sformatf("lane%0dLeftover", j), laneQ[j].size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Watchdog so a stuck design still ends the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/rsa_skew_feeder.md
RSA_SKEW_FEEDER -- requirements
Module: rsa_skew_feeder

Interface
REQ-001 Parameter X, 4, PE array rows (A lanes).
REQ-002 Parameter Y, 4, PE array columns (B lanes, cal_en/cal_done lanes).
REQ-003 Parameter L, 4, maximum inner-dimension beats per job.
REQ-004 Parameter RSA_DW, 32, signed lane data width.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 sys_rst  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  job start pulse; sampled only in IDLE.
REQ-008 k_len  input  $clog2(L)+1  job beat count, sampled with start.
REQ-009 busy  output  1  high in STREAM and DRAIN.
REQ-010 done  output  1  one-cycle pulse at job end.
REQ-011 in_valid  input  1  beat valid.
REQ-012 in_ready  output  1  beat accept; transfer = in_valid && in_ready.
REQ-013 a_col  input  X*RSA_DW  column k of A, lane i at [i*RSA_DW +: RSA_DW].
REQ-014 b_row  input  Y*RSA_DW  row k of B, lane j at [j*RSA_DW +: RSA_DW].
REQ-015 A_data  output  X*RSA_DW  skewed A to array west edge.
REQ-016 B_data  output  Y*RSA_DW  skewed B to array north edge.
REQ-017 new_cal_en  output  Y  per-column beat-valid, aligned with B_data lane j.
REQ-018 new_cal_done  output  Y  per-column last-beat flag, aligned with B_data lane j.

Function
REQ-019 FSM states IDLE, STREAM, DRAIN, DONE; IDLE->STREAM on start with k_len>=1; IDLE->DONE on start with k_len==0.
REQ-020 k_len>L SHALL be clamped to L.
REQ-021 in_ready SHALL be high only in STREAM while accepted beats < job length.
REQ-022 STREAM->DRAIN in the cycle after the last beat transfer; beat counter wraps to 0 on job end.
REQ-023 Transferred beat at edge t SHALL appear on A lane i and B lane j at edges t+1+i and t+1+j respectively (registered, skew = lane index).
REQ-024 new_cal_en[j] SHALL be the transfer strobe delayed 1+j; new_cal_done[j] SHALL be (transfer && last beat) delayed 1+j.
REQ-025 in_valid low in STREAM SHALL insert a bubble: all lanes carry cal_en=0 for that slot, preserving relative skew.
REQ-026 DRAIN SHALL last exactly max(X,Y) cycles, then DONE for one cycle (done=1), then IDLE.
REQ-027 start outside IDLE SHALL be ignored; k_len SHALL be latched only on accepted start.
REQ-028 Data SHALL pass unmodified (no arithmetic); widths equal input widths.

Reset
REQ-029 On sys_rst: FSM IDLE, counters 0, all delay stages 0; busy, done, in_ready, A_data, B_data, new_cal_en, new_cal_done all 0.
REQ-030 Reset mid-job SHALL discard in-flight beats; no done pulse issued.

Configuration
REQ-031 Macro RSA_FEEDER_ZERO_FILL_EN defined: A/B lane data SHALL be 0 in any slot whose strobe is 0 (bubbles, drain, idle).
REQ-032 Macro undefined: non-transfer slots SHALL hold the lane's previous data value; strobes unaffected.

Structure
REQ-033 Shared package rsa_pkg SHALL hold FSM state encoding and RSA_DW default constant.
REQ-034 Sub-module skew_delay_line (parameters DEPTH, W; register chain, DEPTH=0 is wire) SHALL be instanced per lane for data and strobes.

Verification (X=Y=4, L=4, RSA_DW=32)
REQ-035 start, k_len=4, a_col lane i = 10*k+i, b_row lane j = 100*k+j, in_valid continuous -> A lane 2 shows 2,12,22,32 at edges t0+3..t0+6; new_cal_done[3] high once at last-beat+4; done 1 cycle after 4 DRAIN cycles.
REQ-036 k_len=3 with in_valid low on beat 1 -> one bubble slot on every lane (cal_en 0), skew intact, 3 cal_en pulses per column.
REQ-037 start with k_len=0 -> done next-plus-one cycle, no cal_en asserted, in_ready stays 0.
REQ-038 k_len=7 -> clamped, exactly 4 beats accepted, in_ready drops after 4th.
REQ-039 sys_rst asserted after beat 2 -> all outputs 0 immediately, no done; new job after release runs normally.
REQ-040 Bubble with and without RSA_FEEDER_ZERO_FILL_EN -> lane data 0 vs previous value held.
